// File: rtl/freq_meas_pkg.sv
// Shared types and defaults for the frequency counter: FSM encoding,
// default clock/gate constants and the gate-timer width helper.
package freq_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CLK_HZ_DEF      = 27_000_000;
    localparam int GATE_CYCLES_DEF = 27_000;

    // A timer spanning 0..cycles-1 needs at least one bit even for tiny windows.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/freq_meas_sync_edge_det.sv
// Two-flop synchronizer plus a delay flop producing a one-cycle pulse on
// each rising edge of an asynchronous input. Reusable for buttons etc.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/freq_meas.sv
// Frequency counter: counts rising edges of sig_in over a fixed gate window
// of clk and reports the count once per window with a one-cycle strobe.
module freq_meas
    import freq_meas_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEF,
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             cnt_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int                 TIMER_W    = timer_width(GATE_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    // The gate window must fit at least once into a second of clk.
    if (GATE_CYCLES < 2 || CLK_HZ < GATE_CYCLES) begin : g_bad_params
        $error("freq_meas: GATE_CYCLES must be >= 2 and <= CLK_HZ");
    end

    logic               edge_pulse;
    state_t             state_q,    state_d;
    logic [TIMER_W-1:0] timer_q,    timer_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               ovf_q,      ovf_d;
    logic [CNT_W-1:0]   freq_q,     freq_d;
    logic               overflow_q, overflow_d;
    logic               valid_q,    valid_d;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (sig_in),
        .edge_o  (edge_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            freq_q     <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = GATE;
                    timer_d = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            GATE: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    // Saturate rather than wrap so an overrange input is flagged.
                    if (edge_pulse) begin
                        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                        else                  cnt_d = cnt_q + 1'b1;
                    end
                    if (timer_q == TIMER_LAST) state_d = DONE;
                    else                       timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                freq_d     = cnt_q;
                overflow_d = ovf_q;
                valid_d    = 1'b1;
                if (en) begin
                    state_d = GATE;
                    timer_d = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign freq_cnt  = freq_q;
    assign cnt_valid = valid_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == GATE);

endmodule

// File: tb/tb_freq_meas.sv
// Directed bench for freq_meas: two instances (8-bit and 4-bit counters,
// 100-cycle gate) share stimulus; sig_in comes from a clk-timed square wave.
module tb_freq_meas;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sig_in;
    logic [7:0] f8;
    logic       v8, o8, b8;
    logic [3:0] f4;
    logic       v4, o4, b4;

    int   total;
    int   bad;
    int   cyc;
    int   half;
    int   ph;
    logic lvl;

    freq_meas #(.CLK_HZ(27_000_000), .GATE_CYCLES(100), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_cnt(f8), .cnt_valid(v8), .overflow(o8), .busy(b8)
    );

    freq_meas #(.CLK_HZ(27_000_000), .GATE_CYCLES(100), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_cnt(f4), .cnt_valid(v4), .overflow(o4), .busy(b4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Square wave with half-period 'half' clk cycles; half==0 holds sig_in at lvl.
    initial begin
        sig_in = 1'b0;
        ph     = 0;
        forever begin
            @(negedge clk);
            if (half == 0) begin
                sig_in = lvl;
                ph     = 0;
            end else begin
                ph++;
                if (ph >= half) begin
                    ph     = 0;
                    sig_in = ~sig_in;
                end
            end
        end
    end

    task automatic wait_valid(input int max_cyc, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (v8 === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit saw;
        rst  = 1'b1;
        en   = 1'b0;
        lvl  = 1'b0;
        half = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({f8, v8, o8, b8, f4, v4, o4, b4} !== 20'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d got f8=%0d v8=%b o8=%b b8=%b f4=%0d v4=%b o4=%b b4=%b want all 0",
                         i, f8, v8, o8, b8, f4, v4, o4, b4);
            end
        end
        rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (v8 !== 1'b0 || b8 !== 1'b0) saw = 1'b1;
        end
        total++;
        if (saw !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_release got valid_or_busy=%b want 0", saw);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int c0, t, lat;
        bit ok;
        en   = 1'b0;
        half = 5;
        repeat (30) @(negedge clk);
        en = 1'b1;
        c0 = cyc;
        wait_valid(300, t, ok);
        lat = t - c0;
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL basic_timeout got no cnt_valid want one within 300 cycles");
        end
        total++;
        if (lat < 101 || lat > 102) begin
            bad++;
            $display("FAIL basic_latency got %0d want 101..102", lat);
        end
        total++;
        if (f8 !== 8'd10 || o8 !== 1'b0) begin
            bad++;
            $display("FAIL basic_count8 got cnt=%0d ovf=%b want cnt=10 ovf=0", f8, o8);
        end
        total++;
        if (f4 !== 4'd10 || o4 !== 1'b0) begin
            bad++;
            $display("FAIL basic_count4 got cnt=%0d ovf=%b want cnt=10 ovf=0", f4, o4);
        end
        @(negedge clk);
        total++;
        if (v8 !== 1'b0) begin
            bad++;
            $display("FAIL basic_strobe_width got valid=%b want 0 one cycle later", v8);
        end
        $display("test_basic latency=%0d cnt=%0d", lat, f8);
    endtask

    task automatic test_continuous();
        int prev, t;
        bit ok;
        en = 1'b0;
        repeat (5) @(negedge clk);
        half = 10;
        repeat (40) @(negedge clk);
        en = 1'b1;
        wait_valid(300, prev, ok);
        total++;
        if (ok !== 1'b1 || f8 !== 8'd5) begin
            bad++;
            $display("FAIL cont_first got ok=%b cnt=%0d want ok=1 cnt=5", ok, f8);
        end
        for (int k = 0; k < 3; k++) begin
            wait_valid(300, t, ok);
            total++;
            if (ok !== 1'b1 || (t - prev) != 101) begin
                bad++;
                $display("FAIL cont_spacing window=%0d got ok=%b gap=%0d want gap=101", k, ok, t - prev);
            end
            total++;
            if (f8 !== 8'd5 || f4 !== 4'd5) begin
                bad++;
                $display("FAIL cont_count window=%0d got f8=%0d f4=%0d want 5", k, f8, f4);
            end
            $display("test_continuous window=%0d gap=%0d cnt=%0d", k, t - prev, f8);
            prev = t;
        end
    endtask

    task automatic test_saturation();
        int t;
        bit ok;
        en = 1'b0;
        repeat (5) @(negedge clk);
        half = 2;
        repeat (20) @(negedge clk);
        en = 1'b1;
        wait_valid(300, t, ok);
        total++;
        if (ok !== 1'b1 || f4 !== 4'd15 || o4 !== 1'b1) begin
            bad++;
            $display("FAIL sat_cnt4 got ok=%b cnt=%0d ovf=%b want cnt=15 ovf=1", ok, f4, o4);
        end
        total++;
        if (f8 !== 8'd25 || o8 !== 1'b0) begin
            bad++;
            $display("FAIL sat_cnt8 got cnt=%0d ovf=%b want cnt=25 ovf=0", f8, o8);
        end
        en = 1'b0;
        half = 5;
        repeat (30) @(negedge clk);
        en = 1'b1;
        wait_valid(300, t, ok);
        total++;
        if (ok !== 1'b1 || f4 !== 4'd10 || o4 !== 1'b0) begin
            bad++;
            $display("FAIL sat_recover got ok=%b cnt=%0d ovf=%b want cnt=10 ovf=0", ok, f4, o4);
        end
        $display("test_saturation recovered cnt=%0d ovf=%b", f4, o4);
    endtask

    task automatic test_abort();
        int t;
        bit ok, saw;
        en = 1'b0;
        half = 5;
        repeat (30) @(negedge clk);
        en = 1'b1;
        wait_valid(300, t, ok);
        total++;
        if (ok !== 1'b1 || f8 !== 8'd10) begin
            bad++;
            $display("FAIL abort_first got ok=%b cnt=%0d want cnt=10", ok, f8);
        end
        repeat (49) @(negedge clk);
        total++;
        if (b8 !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_mid got busy=%b want 1", b8);
        end
        en = 1'b0;
        @(negedge clk);
        total++;
        if (b8 !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy_fall got busy=%b want 0", b8);
        end
        saw = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (v8 !== 1'b0) saw = 1'b1;
        end
        total++;
        if (saw !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_valid got valid_seen=%b want 0", saw);
        end
        total++;
        if (f8 !== 8'd10 || o8 !== 1'b0) begin
            bad++;
            $display("FAIL abort_hold got cnt=%0d ovf=%b want cnt=10 ovf=0", f8, o8);
        end
        $display("test_abort held cnt=%0d", f8);
    endtask

    task automatic test_static();
        int t;
        bit ok;
        logic lv;
        for (int pass = 0; pass < 2; pass++) begin
            lv   = (pass == 0) ? 1'b1 : 1'b0;
            en   = 1'b0;
            rst  = 1'b1;
            half = 0;
            lvl  = lv;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (10) @(negedge clk);
            en = 1'b1;
            wait_valid(300, t, ok);
            total++;
            if (ok !== 1'b1 || f8 !== 8'd0 || f4 !== 4'd0) begin
                bad++;
                $display("FAIL static_level%0d got ok=%b f8=%0d f4=%0d want 0", lv, ok, f8, f4);
            end
            $display("test_static level=%0d cnt=%0d", lv, f8);
        end
        en = 1'b0;
        half = 5;
        repeat (30) @(negedge clk);
        en = 1'b1;
        wait_valid(300, t, ok);
        total++;
        if (ok !== 1'b1 || f8 !== 8'd10) begin
            bad++;
            $display("FAIL static_pre_reset got ok=%b cnt=%0d want cnt=10", ok, f8);
        end
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({f8, v8, o8, b8, f4, v4, o4, b4} !== 20'd0) begin
            bad++;
            $display("FAIL midwindow_reset got f8=%0d v8=%b o8=%b b8=%b f4=%0d want all 0",
                     f8, v8, o8, b8, f4);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        $display("test_static midwindow reset busy=%b cnt=%0d", b8, f8);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        lvl   = 1'b0;
        half  = 0;
        test_reset();
        test_basic();
        test_continuous();
        test_saturation();
        test_abort();
        test_static();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
